fp_dot_accum_seq: RTL and testbench
===================================

// Module: fp_dot_accum_seq
// PURPOSE
// - Streaming dot-product sequencer wrapped around the combinational FP MAC
//   (mac_out = a*b + c). Drives MAC operands and consumes MAC result every beat.
// - Accepts (a,b) element pairs over valid/ready and folds each product into a
//   registered accumulator seeded with a per-vector bias.
// - Emits one accumulated scalar per vector on a valid/ready output. MAC is external.
// PARAMETERS
// - BIT_WIDTH  16  FP word width (bfloat16: 1S 8E 7M); must match the MAC instance
// - CNT_WIDTH  8   width of beat counter; max vector length = 2**CNT_WIDTH-1
// PORTS
// - clk        in   1          single clock, rising edge
// - rst        in   1          synchronous, active-high reset
// - in_valid   in   1          element pair valid
// - in_ready   out  1          sequencer can accept element
// - in_a       in   BIT_WIDTH  multiplicand element
// - in_b       in   BIT_WIDTH  multiplier element
// - in_bias    in   BIT_WIDTH  accumulator seed; sampled only on first beat of a vector
// - in_last    in   1          marks final element of vector
// - mac_a      out  BIT_WIDTH  to MAC in_a (comb = in_a)
// - mac_b      out  BIT_WIDTH  to MAC in_b (comb = in_b)
// - mac_c      out  BIT_WIDTH  to MAC in_c (comb: in_bias if first beat, else acc)
// - mac_res    in   BIT_WIDTH  from MAC mac_out, same cycle
// - out_valid  out  1          result valid
// - out_ready  in   1          downstream accepts result
// - out_data   out  BIT_WIDTH  accumulated dot product (= acc register)
// - out_len    out  CNT_WIDTH  beats folded into out_data
// - len_err    out  1          sticky: vector truncated at max length
// BEHAVIOUR
// - Reset (sync): state=IDLE, acc=0, cnt=0, out_valid=0, in_ready=0 during rst,
//   len_err=0. out_data/out_len read 0 after reset.
// - Beat accepted = in_valid & in_ready at rising clk.
// - States: IDLE (no beat yet), ACCUM (>=1 beat), DONE (result held).
// - IDLE: in_ready=1. mac_c=in_bias. On beat: acc<=mac_res, cnt<=1;
//   -> DONE if in_last, else -> ACCUM.
// - ACCUM: in_ready=1. mac_c=acc. On beat: acc<=mac_res, cnt<=cnt+1;
//   -> DONE if in_last or cnt+1 == 2**CNT_WIDTH-1 (latter also sets len_err).
// - DONE: in_ready=0, out_valid=1, out_data=acc, out_len=cnt. Stable until
//   out_ready; on handshake -> IDLE, cnt<=0 (acc keeps value, unused).
// - Latency: out_valid rises the cycle after the last beat is accepted; one
//   beat per cycle throughput within a vector; one bubble cycle per vector.
// - No beat: acc/cnt hold; in_valid low in ACCUM stalls indefinitely.
// - mac_a/mac_b/mac_c are driven every cycle regardless of in_valid; acc only
//   updates on an accepted beat. Single-element vector (in_last on first beat)
//   gives out_data = a*b + bias, out_len=1.
// - No FP arithmetic here; rounding/exceptions are owned by the MAC.
// - len_err clears only on rst. rst mid-vector discards acc and any held result.
// TESTING
// - Bench instantiates the MAC (BIT_WIDTH=16, EXP 8, MANT 7) on mac_* ports.
// - Vector {(3F80,4000),(4040,3F80) last}, bias 3F00 -> out_data 40B0 (5.5), out_len 2,
//   out_valid one cycle after 2nd beat.
// - Single beat (4000,4000) last, bias 0000 -> out_data 4080, out_len 1.
// - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, out_* stable,
//   no beat taken; then out_ready=1 -> IDLE, next beat seeds from new bias.
// - Gaps: in_valid toggled 1,0,0,1(last) with (3F80,3F80) each, bias 0 -> 4000, len 2.
// - CNT_WIDTH=2: 4 beats (3F80,3F80) no last -> DONE after 3rd beat, out 4040, len 3,
//   len_err=1 and stays set; 4th element starts new vector.
// - Assert rst during ACCUM -> next cycle out_valid=0, state IDLE, len_err=0.

Source files
------------

// File: rtl/fp_dot_accum_seq.sv
// fp_dot_accum_seq: streaming dot-product sequencer around an external
// combinational FP MAC (mac_out = a*b + c). Each accepted (a,b) pair is folded
// into a registered accumulator that is seeded with a per-vector bias on the
// first beat. One accumulated scalar is emitted per vector over valid/ready.
module fp_dot_accum_seq #(
    parameter int BIT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic [BIT_WIDTH-1:0] in_bias,
    input  logic                 in_last,
    output logic [BIT_WIDTH-1:0] mac_a,
    output logic [BIT_WIDTH-1:0] mac_b,
    output logic [BIT_WIDTH-1:0] mac_c,
    input  logic [BIT_WIDTH-1:0] mac_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_len,
    output logic                 len_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BIT_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 at_max;
    logic                 beat;
    logic                 set_len_err;

    assign cnt_inc   = cnt + CNT_WIDTH'(1);
    // Counter saturates at all-ones (2**CNT_WIDTH-1 beats), forcing the vector closed.
    assign at_max    = (cnt_inc == '1);

    assign in_ready  = !rst && (state != DONE);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_len   = cnt;
    assign mac_a     = in_a;
    assign mac_b     = in_b;

    // State register, accumulator, beat counter and sticky length error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (beat) begin
                acc <= mac_res;
            end
            if (set_len_err) begin
                len_err <= 1'b1;
            end
        end
    end

    // Next-state, counter update and MAC addend selection.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        mac_c       = acc;
        set_len_err = 1'b0;
        case (state)
            IDLE: begin
                mac_c = in_bias;
                if (beat) begin
                    cnt_next   = CNT_WIDTH'(1);
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    cnt_next = cnt_inc;
                    if (in_last || at_max) begin
                        state_next = DONE;
                    end
                    set_len_err = at_max;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_dot_accum_seq.sv
// Directed bench for fp_dot_accum_seq. A small bfloat16 a*b+c model stands in
// for the external MAC; all stimulus values are exactly representable so the
// model needs no rounding. A second instance with CNT_WIDTH=2 covers the
// length-saturation path.
module tb_fp_dot_accum_seq;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, len_err;
    logic [15:0] in_a, in_b, in_bias, mac_a, mac_b, mac_c, mac_res, out_data;
    logic [7:0]  out_len;

    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_len_err;
    logic [15:0] s_in_a, s_in_b, s_in_bias, s_mac_a, s_mac_b, s_mac_c, s_mac_res, s_out_data;
    logic [1:0]  s_out_len;

    int unsigned total;
    int unsigned passed;

    fp_dot_accum_seq #(.BIT_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_last(in_last),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_res(mac_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_len(out_len), .len_err(len_err)
    );

    fp_dot_accum_seq #(.BIT_WIDTH(16), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_bias(s_in_bias), .in_last(s_in_last),
        .mac_a(s_mac_a), .mac_b(s_mac_b), .mac_c(s_mac_c), .mac_res(s_mac_res),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_len(s_out_len), .len_err(s_len_err)
    );

    // bfloat16 -> real (normal numbers and zero only)
    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[14:7] == 8'd0) return 0.0;
        e = {3'b000, x[14:7]} - 11'd127 + 11'd1023;
        d = {x[15], e, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    // real -> bfloat16 (truncating; inputs here are exact)
    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 15'd0};
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    always_comb mac_res   = r2bf(bf2r(mac_a) * bf2r(mac_b) + bf2r(mac_c));
    always_comb s_mac_res = r2bf(bf2r(s_mac_a) * bf2r(s_mac_b) + bf2r(s_mac_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        in_valid = 1'b1; in_a = '0; in_b = '0; in_bias = '0; in_last = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_bias = '0; s_in_last = 1'b0;
        s_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_len", 32'(out_len), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();

        // Two-beat vector: 1*2 + 0.5 = 2.5, then 3*1 + 2.5 = 5.5
        in_a = 16'h3F80; in_b = 16'h4000; in_bias = 16'h3F00; in_last = 1'b0; in_valid = 1'b1;
        #1;
        chk("v1_in_ready", 32'(in_ready), 32'd1);
        chk("v1_mac_a", 32'(mac_a), 32'h3F80);
        chk("v1_mac_c_bias", 32'(mac_c), 32'h3F00);
        tick();
        chk("v1_no_early_valid", 32'(out_valid), 32'd0);
        in_a = 16'h4040; in_b = 16'h3F80; in_bias = 16'h0000; in_last = 1'b1;
        #1;
        chk("v1_mac_c_acc", 32'(mac_c), 32'h4020);
        tick();
        in_valid = 1'b0;
        chk("v1_out_valid", 32'(out_valid), 32'd1);
        chk("v1_out_data", 32'(out_data), 32'h40B0);
        chk("v1_out_len", 32'(out_len), 32'd2);
        chk("v1_in_ready_done", 32'(in_ready), 32'd0);
        tick();
        chk("v1_back_idle", 32'(out_valid), 32'd0);
        chk("v1_ready_idle", 32'(in_ready), 32'd1);

        // Single beat: 2*2 + 0 = 4
        in_a = 16'h4000; in_b = 16'h4000; in_bias = 16'h0000; in_last = 1'b1; in_valid = 1'b1;
        tick();
        chk("v2_out_valid", 32'(out_valid), 32'd1);
        chk("v2_out_data", 32'(out_data), 32'h4080);
        chk("v2_out_len", 32'(out_len), 32'd1);

        // Backpressure in DONE with a pending element offered
        out_ready = 1'b0;
        in_a = 16'h3F80; in_b = 16'h3F80; in_bias = 16'h4000; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_data", 32'(out_data), 32'h4080);
            chk("hold_out_len", 32'(out_len), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_mac_c_bias", 32'(mac_c), 32'h4000);
        tick();
        in_valid = 1'b0;
        chk("v3_out_data", 32'(out_data), 32'h4040);
        chk("v3_out_len", 32'(out_len), 32'd1);
        tick();

        // Gaps within a vector: beats on cycles 1 and 4
        in_a = 16'h3F80; in_b = 16'h3F80; in_bias = 16'h0000; in_last = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("gap_stall_valid", 32'(out_valid), 32'd0);
        chk("gap_stall_mac_c", 32'(mac_c), 32'h3F80);
        chk("gap_stall_len", 32'(out_len), 32'd1);
        in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("gap_out_valid", 32'(out_valid), 32'd1);
        chk("gap_out_data", 32'(out_data), 32'h4000);
        chk("gap_out_len", 32'(out_len), 32'd2);
        tick();

        // CNT_WIDTH=2: vector forced closed after 3 beats
        s_in_a = 16'h3F80; s_in_b = 16'h3F80; s_in_bias = 16'h0000; s_in_last = 1'b0; s_in_valid = 1'b1;
        tick();
        tick();
        chk("sat_len_err_early", 32'(s_len_err), 32'd0);
        chk("sat_not_done", 32'(s_out_valid), 32'd0);
        tick();
        chk("sat_out_valid", 32'(s_out_valid), 32'd1);
        chk("sat_out_data", 32'(s_out_data), 32'h4040);
        chk("sat_out_len", 32'(s_out_len), 32'd3);
        chk("sat_len_err", 32'(s_len_err), 32'd1);
        chk("sat_in_ready", 32'(s_in_ready), 32'd0);
        s_in_last = 1'b1; s_in_bias = 16'h3F00;
        tick();
        chk("sat_idle_valid", 32'(s_out_valid), 32'd0);
        chk("sat_idle_ready", 32'(s_in_ready), 32'd1);
        chk("sat_new_bias", 32'(s_mac_c), 32'h3F00);
        chk("sat_err_sticky", 32'(s_len_err), 32'd1);
        tick();
        s_in_valid = 1'b0;
        chk("sat4_out_data", 32'(s_out_data), 32'h3FC0);
        chk("sat4_out_len", 32'(s_out_len), 32'd1);
        chk("sat4_err_sticky", 32'(s_len_err), 32'd1);
        tick();

        // Reset while accumulating
        in_a = 16'h3F80; in_b = 16'h3F80; in_bias = 16'h0000; in_last = 1'b0; in_valid = 1'b1;
        tick();
        chk("pre_rst_len", 32'(out_len), 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        in_bias = 16'h3F00;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_len", 32'(out_len), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        chk("mid_rst_idle_mac_c", 32'(mac_c), 32'h3F00);
        chk("mid_rst_len_err_small", 32'(s_len_err), 32'd0);
        chk("mid_rst_len_err", 32'(len_err), 32'd0);
        tick();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
